output_port_bank: RTL and testbench
===================================

# output_port_bank

Parametrised memory-mapped output port bank for the 8-bit CPU. It replaces fixed 16×8 output latches with a configurable bank. Each port is a register written from the CPU data bus, with four write operations: write, set, clear and toggle. Ports can be configured to auto-clear after a programmed pulse length. The bank also provides registered read-back and per-port update strobes. It sits on the CPU data/address bus next to the input ports and drives external peripherals.

## Interface
- DATA_W, 8, width of each port and of the data bus
- ADDR_W, 8, address bus width
- NUM_PORTS, 16, number of ports (1..2^ADDR_W - BASE_ADDR)
- BASE_ADDR, 8'hF0, address of port 0; port i sits at BASE_ADDR+i
- PULSE_MASK, 0, NUM_PORTS-bit mask; bit i=1 puts port i in pulse (auto-clear) mode
- PULSE_LEN, 4, cycles a pulse-mode port holds a nonzero value (>=1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- address  in  ADDR_W  bus address
- write  in  1  write enable, sampled at clk rise
- wr_op  in  2  write operation: 00 load, 01 set (OR), 10 clear (AND NOT), 11 toggle (XOR)
- data_in  in  DATA_W  write data / bit mask
- read  in  1  read-back enable
- data_out  out  DATA_W  registered read-back data
- hit  out  1  registered: previous-cycle read addressed a valid port
- port_out  out  NUM_PORTS*DATA_W  flattened port registers, port i at bits [i*DATA_W +: DATA_W]
- port_stb  out  NUM_PORTS  one-cycle pulse per port when its register changes by CPU write

## Operation
- Decode: port i is selected when address == BASE_ADDR+i, compared at full ADDR_W width. Addresses outside [BASE_ADDR, BASE_ADDR+NUM_PORTS-1] are ignored for both write and read.
- Write: when write=1 and a port is selected, the next value of that port is computed from wr_op:
  - 00: data_in
  - 01: old | data_in
  - 10: old & ~data_in
  - 11: old ^ data_in
- Only the selected port changes; all other ports hold their values.
- port_stb[i]: registered, high for exactly one cycle after a write to port i whose result differs from the old value. A write that leaves the value unchanged produces no strobe.
- Pulse mode, for ports with PULSE_MASK[i]=1. Each such port has a counter sized to $clog2(PULSE_LEN+1).
  - A write producing a nonzero value loads the counter with PULSE_LEN.
  - A write producing zero clears the counter.
  - While the counter is nonzero it decrements every cycle.
  - On the edge where the counter goes 1→0, the port clears to 0. The value is therefore visible for exactly PULSE_LEN cycles.
  - The auto-clear does not raise port_stb.
- Rewrite during a pulse: the new value is applied and the counter reloads to PULSE_LEN. A write takes priority over an auto-clear on the same edge.
- Ports with PULSE_MASK[i]=0 hold their value indefinitely. No counter logic is generated for them.
- Read-back: when read=1 at a clk rise, data_out is loaded with the selected port's pre-edge value and hit is set to 1. On a miss, data_out=0 and hit=0. When read=0, data_out and hit hold.
- Simultaneous read and write to the same port: data_out returns the old value. The new value is readable from the next read.

## Timing
- Reset (reset=0, asynchronous): all port_out=0, all counters=0, port_stb=0, data_out=0, hit=0. This holds regardless of any operation in progress. A pulse in progress is aborted, and no strobe is produced on release.
- Outputs are valid after the first clk rise following reset deassertion.
- Write latency: port_out updates at the same clk edge that samples write. port_stb is high during the cycle after that edge.
- Read latency: 1 cycle; data_out and hit are valid after the edge that samples read.
- Pulse: a nonzero write at edge 0 is visible at edges 0..PULSE_LEN-1 and reads as 0 after edge PULSE_LEN.
- No handshake and no stall: one write and one read are accepted per cycle.

## Test plan
- Reset with writes pending: assert reset mid-cycle after writing 8'hAA to F3 → port_out, data_out, hit and port_stb all 0 immediately; after release, reading F3 gives 8'h00 with hit=1.
- Ops on F5 (default params):
  - load 8'h0F → port 8'h0F, stb=1
  - set 8'hF0 → 8'hFF, stb=1
  - clear 8'h0F → 8'hF0, stb=1
  - toggle 8'hFF → 8'h0F, stb=1
  - set 8'h0F → 8'h0F, stb=0
- Decode boundaries: writes to EF and 00 leave all ports unchanged. A write to FF updates only port 15. Reading EF gives data_out=0, hit=0.
- Pulse (PULSE_MASK=16'h0001, PULSE_LEN=4):
  - write 8'h01 to F0 → port_out[7:0]=1 for 4 cycles, then 0, with no stb on the clear
  - rewrite 8'h02 at cycle 2 → value held for 4 more cycles
  - write 8'h00 → immediate clear
- Read/write collision: F2=8'h11; in one cycle write 8'h22 and read F2 → data_out=8'h11, port_out=8'h22; the next read gives 8'h22.
- Parametrisation: DATA_W=16, NUM_PORTS=4, BASE_ADDR=8'h80 → load 16'hBEEF to 83 and read back 16'hBEEF; address 84 misses.

Source files
------------

// File: rtl/output_port_bank_if.sv
// CPU-side bus of the output port bank: address/strobes/write data from the
// CPU, registered read-back data and hit flag towards the CPU.
interface output_port_bank_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) ();
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [1:0]        wr_op;
   logic [DATA_W-1:0] data_in;
   logic              read;
   logic [DATA_W-1:0] data_out;
   logic              hit;

   modport master (
      output address, write, wr_op, data_in, read,
      input  data_out, hit
   );

   modport slave (
      input  address, write, wr_op, data_in, read,
      output data_out, hit
   );
endinterface

// File: rtl/output_port_bank.sv
// Memory-mapped bank of CPU output ports with load/set/clear/toggle writes,
// optional auto-clearing pulse ports, registered read-back and change strobes.
module output_port_bank #(
   parameter int                    DATA_W     = 8,
   parameter int                    ADDR_W     = 8,
   parameter int                    NUM_PORTS  = 16,
   parameter logic [ADDR_W-1:0]     BASE_ADDR  = 8'hF0,
   parameter logic [NUM_PORTS-1:0]  PULSE_MASK = '0,
   parameter int                    PULSE_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   output_port_bank_if.slave             bus,
   output logic [NUM_PORTS*DATA_W-1:0]   port_out,
   output logic [NUM_PORTS-1:0]          port_stb
);

   localparam int CNT_W = $clog2(PULSE_LEN + 1);

   logic [NUM_PORTS-1:0] sel;
   logic [DATA_W-1:0]    rd_val;
   logic                 rd_hit;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(BASE_ADDR + gi);

      logic [DATA_W-1:0] val_q;
      logic [DATA_W-1:0] wr_val;
      logic              wr_en;
      logic              stb_q;

      // full-width compare so aliased addresses never select a port
      assign sel[gi] = (bus.address == PORT_ADDR);
      assign wr_en   = bus.write & sel[gi];

      // value this port would take if the current bus write targets it
      always_comb begin
         wr_val = val_q;
         case (bus.wr_op)
            2'b00:   wr_val = bus.data_in;
            2'b01:   wr_val = val_q | bus.data_in;
            2'b10:   wr_val = val_q & ~bus.data_in;
            default: wr_val = val_q ^ bus.data_in;
         endcase
      end

      if (PULSE_MASK[gi]) begin : g_pulse
         logic [CNT_W-1:0] cnt_q;

         // port register with down-counter; a CPU write beats the auto-clear
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               val_q <= '0;
               cnt_q <= '0;
            end else if (wr_en) begin
               val_q <= wr_val;
               cnt_q <= (wr_val != '0) ? CNT_W'(PULSE_LEN) : '0;
            end else if (cnt_q != '0) begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) val_q <= '0;
            end
         end
      end else begin : g_hold
         // plain latch-style port register, holds until rewritten
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)     val_q <= '0;
            else if (wr_en) val_q <= wr_val;
         end
      end

      // strobe only for CPU writes that actually change the value
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) stb_q <= 1'b0;
         else        stb_q <= wr_en && (wr_val != val_q);
      end

      assign port_out[gi*DATA_W +: DATA_W] = val_q;
      assign port_stb[gi]                  = stb_q;
   end

   // read-back mux over the pre-edge port values
   always_comb begin
      rd_val = '0;
      rd_hit = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel[i]) begin
            rd_val = port_out[i*DATA_W +: DATA_W];
            rd_hit = 1'b1;
         end
      end
   end

   // registered read-back; holds when no read is issued
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.data_out <= '0;
         bus.hit      <= 1'b0;
      end else if (bus.read) begin
         bus.data_out <= rd_val;
         bus.hit      <= rd_hit;
      end
   end

endmodule

// File: tb/tb_output_port_bank.sv
// Bench for output_port_bank: reference model of ports/pulse deadlines/read-back,
// per-cycle comparison, directed literal checks and randomized traffic.
module tb_output_port_bank;
   localparam int          NP   = 16;
   localparam int          LEN  = 4;
   localparam logic [15:0] MASK = 16'h0001;
   localparam int          BASE = 'hF0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   output_port_bank_if #(.DATA_W(8),  .ADDR_W(8)) bus ();
   output_port_bank_if #(.DATA_W(16), .ADDR_W(8)) bus2 ();

   logic [127:0] port_out;
   logic [15:0]  port_stb;
   logic [63:0]  port_out2;
   logic [3:0]   port_stb2;

   output_port_bank #(.PULSE_MASK(MASK), .PULSE_LEN(LEN)) dut (
      .clk(clk), .reset(reset), .bus(bus), .port_out(port_out), .port_stb(port_stb)
   );

   output_port_bank #(.DATA_W(16), .NUM_PORTS(4), .BASE_ADDR(8'h80)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .port_out(port_out2), .port_stb(port_stb2)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // reference model: port values, absolute expiry cycle of pulse ports
   logic [7:0]  m_port [NP];
   int          m_dl   [NP];
   logic [15:0] m_stb;
   logic [7:0]  m_dout;
   logic        m_hit;
   int          m_cyc = 0;
   int          m_idx;
   logic        m_in, m_wr;
   logic [7:0]  m_old, m_nv;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NP; i++) begin
            m_port[i] = 8'h00;
            m_dl[i]   = -1;
         end
         m_stb  = '0;
         m_dout = 8'h00;
         m_hit  = 1'b0;
      end else begin
         m_cyc++;
         m_idx = int'(bus.address) - BASE;
         m_in  = (m_idx >= 0) && (m_idx < NP);
         if (bus.read) begin
            m_hit  = m_in;
            m_dout = m_in ? m_port[m_idx[3:0]] : 8'h00;
         end
         m_stb = '0;
         m_wr  = bus.write && m_in;
         m_old = 8'h00;
         m_nv  = 8'h00;
         if (m_wr) begin
            m_old = m_port[m_idx[3:0]];
            case (bus.wr_op)
               2'd0:    m_nv = bus.data_in;
               2'd1:    m_nv = m_old | bus.data_in;
               2'd2:    m_nv = m_old & ~bus.data_in;
               default: m_nv = m_old ^ bus.data_in;
            endcase
         end
         for (int i = 0; i < NP; i++)
            if (MASK[i] && !(m_wr && i == m_idx) && m_dl[i] == m_cyc) m_port[i] = 8'h00;
         if (m_wr) begin
            m_stb[m_idx[3:0]]  = (m_nv != m_old);
            m_port[m_idx[3:0]] = m_nv;
            if (MASK[m_idx[3:0]]) m_dl[m_idx[3:0]] = (m_nv != 8'h00) ? m_cyc + LEN : -1;
         end
      end
   end

   // compare DUT against model every cycle, away from the rising edge
   always @(negedge clk) begin
      logic [127:0] flat;
      for (int i = 0; i < NP; i++) flat[i*8 +: 8] = m_port[i];
      chk("model_port_out", port_out, flat);
      chk("model_port_stb", 128'(port_stb), 128'(m_stb));
      chk("model_data_out", 128'(bus.data_out), 128'(m_dout));
      chk("model_hit", 128'(bus.hit), 128'(m_hit));
   end

   task automatic drive(input logic w, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] d, input logic r);
      @(negedge clk);
      bus.write = w; bus.wr_op = op; bus.address = a; bus.data_in = d; bus.read = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic drive2(input logic w, input logic [7:0] a, input logic [15:0] d, input logic r);
      @(negedge clk);
      bus2.write = w; bus2.wr_op = 2'd0; bus2.address = a; bus2.data_in = d; bus2.read = r;
      @(posedge clk);
      #1;
      bus2.write = 1'b0; bus2.read = 1'b0;
   endtask

   function automatic logic [7:0] pv(input int i);
      return port_out[i*8 +: 8];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end

   initial begin
      logic [127:0] save, exp_v;
      logic [1:0]  ops  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      logic [7:0]  dats [5] = '{8'h0F, 8'hF0, 8'h0F, 8'hFF, 8'h0F};
      logic [7:0]  vals [5] = '{8'h0F, 8'hFF, 8'hF0, 8'h0F, 8'h0F};
      logic        stbs [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int          r;

      bus.write = 0; bus.wr_op = 0; bus.address = 0; bus.data_in = 0; bus.read = 0;
      bus2.write = 0; bus2.wr_op = 0; bus2.address = 0; bus2.data_in = 0; bus2.read = 0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // reset with a write pending/visible
      drive(1, 2'd0, 8'hF3, 8'hAA, 0);
      chk("f3_written", 128'(pv(3)), 128'(8'hAA));
      chk("f3_stb", 128'(port_stb[3]), 128'(1'b1));
      drive(0, 2'd0, 8'hF3, 8'h00, 1);
      chk("f3_read", 128'(bus.data_out), 128'(8'hAA));
      #2 reset = 1'b0;
      #1;
      chk("rst_port_out", port_out, 128'h0);
      chk("rst_data_out", 128'(bus.data_out), 128'h0);
      chk("rst_hit", 128'(bus.hit), 128'h0);
      chk("rst_stb", 128'(port_stb), 128'h0);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 2'd0, 8'hF3, 8'h00, 1);
      chk("post_rst_read", 128'(bus.data_out), 128'(8'h00));
      chk("post_rst_hit", 128'(bus.hit), 128'(1'b1));

      // four write operations on F5
      for (int k = 0; k < 5; k++) begin
         drive(1, ops[k], 8'hF5, dats[k], 0);
         chk($sformatf("f5_op%0d_val", k), 128'(pv(5)), 128'(vals[k]));
         chk($sformatf("f5_op%0d_stb", k), 128'(port_stb[5]), 128'(stbs[k]));
      end

      // decode boundaries
      save = port_out;
      drive(1, 2'd0, 8'hEF, 8'h55, 0);
      chk("wr_ef_ignored", port_out, save);
      drive(1, 2'd0, 8'h00, 8'h55, 0);
      chk("wr_00_ignored", port_out, save);
      drive(1, 2'd0, 8'hFF, 8'h3C, 0);
      exp_v = save;
      exp_v[120 +: 8] = 8'h3C;
      chk("wr_ff_port15", port_out, exp_v);
      drive(0, 2'd0, 8'hF5, 8'h00, 1);
      chk("rd_f5", 128'(bus.data_out), 128'(8'h0F));
      drive(0, 2'd0, 8'hEF, 8'h00, 1);
      chk("rd_ef_data", 128'(bus.data_out), 128'h0);
      chk("rd_ef_hit", 128'(bus.hit), 128'h0);

      // pulse port 0
      drive(1, 2'd0, 8'hF0, 8'h01, 0);
      chk("pulse_e0", 128'(pv(0)), 128'(8'h01));
      for (int k = 1; k < LEN; k++) begin
         idle();
         chk($sformatf("pulse_e%0d", k), 128'(pv(0)), 128'(8'h01));
      end
      idle();
      chk("pulse_cleared", 128'(pv(0)), 128'h0);
      chk("pulse_clear_nostb", 128'(port_stb[0]), 128'h0);
      drive(1, 2'd0, 8'hF0, 8'h01, 0);
      idle();
      drive(1, 2'd0, 8'hF0, 8'h02, 0);
      for (int k = 0; k < LEN; k++) begin
         chk($sformatf("rewrite_e%0d", k), 128'(pv(0)), 128'(8'h02));
         idle();
      end
      chk("rewrite_cleared", 128'(pv(0)), 128'h0);
      drive(1, 2'd0, 8'hF0, 8'h05, 0);
      drive(1, 2'd0, 8'hF0, 8'h00, 0);
      chk("pulse_zero_write", 128'(pv(0)), 128'h0);

      // read/write collision on F2
      drive(1, 2'd0, 8'hF2, 8'h11, 0);
      drive(1, 2'd0, 8'hF2, 8'h22, 1);
      chk("coll_old_read", 128'(bus.data_out), 128'(8'h11));
      chk("coll_new_port", 128'(pv(2)), 128'(8'h22));
      drive(0, 2'd0, 8'hF2, 8'h00, 1);
      chk("coll_next_read", 128'(bus.data_out), 128'(8'h22));

      // 16-bit, 4-port bank at 0x80
      drive2(1, 8'h83, 16'hBEEF, 0);
      chk("p16_port3", 128'(port_out2[48 +: 16]), 128'(16'hBEEF));
      chk("p16_stb3", 128'(port_stb2), 128'(4'b1000));
      drive2(0, 8'h83, 16'h0000, 1);
      chk("p16_read", 128'(bus2.data_out), 128'(16'hBEEF));
      chk("p16_hit", 128'(bus2.hit), 128'(1'b1));
      drive2(0, 8'h84, 16'h0000, 1);
      chk("p16_miss_data", 128'(bus2.data_out), 128'h0);
      chk("p16_miss_hit", 128'(bus2.hit), 128'h0);

      // randomized traffic with occasional mid-cycle reset
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         reset = 1'b1;
         r = int'($urandom_range(0, 9));
         if (r < 2)      bus.address = 8'hF0;
         else if (r < 7) bus.address = 8'(BASE + int'($urandom_range(0, NP - 1)));
         else if (r < 9) bus.address = 8'($urandom_range(8'hEC, 8'hEF));
         else            bus.address = 8'($urandom);
         bus.write   = ($urandom_range(0, 1) == 1);
         bus.wr_op   = 2'($urandom);
         bus.data_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         bus.read    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #7 reset = 1'b0;
         end
      end
      @(negedge clk);
      reset = 1'b1;
      bus.write = 1'b0; bus.read = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
